mtrx_add_ctrl: RTL and testbench
================================

// Module: mtrx_add_ctrl
// PURPOSE
//   Sequencer for the 5x5 8-bit matrix adder. Loads A then B row-by-row over a
//   valid/ready stream into 200-bit operand registers that drive the adder.
//   Waits out the adder latency, captures C, then streams C out row-by-row.
//   Sits between the host/bus-side row stream and the registered matrix adder.
// PARAMETERS
//   ROWS         5  matrix rows
//   COLS         5  matrix columns (elements per row)
//   W            8  element width, bits
//   ADD_LATENCY  1  adder clock latency (registered adder = 1)
//   Derived: RW = COLS*W (40), MW = ROWS*RW (200)
// PORTS
//   clock      in   1   system clock
//   reset      in   1   async, active-high
//   start      in   1   begin operation; sampled only in IDLE
//   busy       out  1   high whenever state != IDLE
//   in_valid   in   1   input row valid
//   in_ready   out  1   high in LOAD_A / LOAD_B only
//   in_row     in   RW  input row; element j at [j*W +: W]
//   adder_a    out  MW  operand A to adder; row r at [r*RW +: RW]
//   adder_b    out  MW  operand B to adder, same packing
//   adder_c    in   MW  adder result, same packing
//   out_valid  out  1   result row valid (DRAIN only)
//   out_ready  in   1   downstream accepts row
//   out_row    out  RW  result row
//   out_last   out  1   high with row ROWS-1
//   out_ovf    out  COLS per-element wrap flags for out_row (see CONFIGURATION)
//   done       out  1   one-cycle pulse after last result row accepted
// BEHAVIOUR
//   - Reset (async): state IDLE; counters 0; adder_a/adder_b/result buffer 0;
//     all outputs 0 (in_ready, out_valid, busy, done, out_last, out_ovf low).
//   - States: IDLE -> LOAD_A -> LOAD_B -> WAIT -> DRAIN -> IDLE.
//   - IDLE: start=1 -> LOAD_A, row_cnt=0. start outside IDLE ignored.
//   - LOAD_A/LOAD_B: beat = in_valid & in_ready; writes in_row into row row_cnt
//     of adder_a/adder_b; row_cnt increments, wraps to 0 after ROWS-1.
//     Beat on row ROWS-1: LOAD_A -> LOAD_B, LOAD_B -> WAIT. No beat = hold.
//   - WAIT: lasts exactly ADD_LATENCY+1 cycles (lat_cnt); on its final edge
//     adder_c is captured into the result buffer, state -> DRAIN, row_cnt=0.
//   - DRAIN: out_valid=1, out_row=buffer row row_cnt; row advances only on
//     out_valid & out_ready; out_row/out_last/out_ovf stable while stalled.
//     Handshake on row ROWS-1 -> IDLE, done=1 for that next cycle only.
//   - adder_a/adder_b hold their values until overwritten by the next load.
//   - Latency, in_valid and out_ready held high: start sampled at edge S;
//     beats at S+1..S+10; capture at S+12; out_valid high after S+12;
//     rows accepted S+13..S+17; done high after S+17.
//   - Arithmetic is the adder's: per-element modulo 2^W, no carry between lanes.
//   - Reset mid-operation: immediate return to IDLE, partial loads discarded.
// CONFIGURATION
//   MTRX_ADD_CTRL_OVF_EN defined: at capture, flag[e] = (c_e < a_e) per element
//     (unsigned wrap); out_ovf presents the COLS flags of the current out_row.
//   Not defined: out_ovf tied to 0, no flag storage synthesised.
// TESTING
//   1 A=1..25, B=25..1, valids/readies held high -> 5 rows of all 26 (0x1a),
//     out_last on row 4, done 1 cycle after, timing exactly as Latency bullet.
//   2 in_valid toggled every other cycle during load -> only beats counted;
//     result identical to test 1; in_ready low in WAIT/DRAIN.
//   3 out_ready low 3 cycles on row 2 -> out_row stable, no row skipped.
//   4 A all 0xF0, B all 0x20 -> every element 0x10; out_ovf=5'b11111 with
//     OVF_EN, 0 without.
//   5 reset asserted after 3 B beats -> busy/outputs 0 at once; fresh start
//     with test 1 data yields correct 26s.
//   6 start pulsed during LOAD_B and DRAIN -> ignored, single done pulse.

Source files
------------

// File: rtl/mtrx_add_ctrl_if.sv
// Row-stream bundle between the host side and the matrix-adder sequencer.
// slave is the sequencer's view; master is the host/bus side.
interface mtrx_add_ctrl_if #(
  parameter int unsigned COLS = 5,
  parameter int unsigned W    = 8
);
  localparam int unsigned RW = COLS * W;

  logic            in_valid;
  logic            in_ready;
  logic [RW-1:0]   in_row;
  logic            out_valid;
  logic            out_ready;
  logic [RW-1:0]   out_row;
  logic            out_last;
  logic [COLS-1:0] out_ovf;

  modport slave (
    input  in_valid, in_row, out_ready,
    output in_ready, out_valid, out_row, out_last, out_ovf
  );

  modport master (
    output in_valid, in_row, out_ready,
    input  in_ready, out_valid, out_row, out_last, out_ovf
  );
endinterface

// File: rtl/mtrx_add_ctrl.sv
// Sequencer for the registered ROWSxCOLS matrix adder: load A, load B, wait, drain C.
// Define MTRX_ADD_CTRL_OVF_EN to store and present per-element wrap flags on out_ovf.
module mtrx_add_ctrl #(
  parameter int unsigned ROWS        = 5,
  parameter int unsigned COLS        = 5,
  parameter int unsigned W           = 8,
  parameter int unsigned ADD_LATENCY = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  output logic                     busy,
  output logic [ROWS*COLS*W-1:0]   adder_a,
  output logic [ROWS*COLS*W-1:0]   adder_b,
  input  logic [ROWS*COLS*W-1:0]   adder_c,
  output logic                     done,
  mtrx_add_ctrl_if.slave           strm
);
  localparam int unsigned RW  = COLS * W;
  localparam int unsigned MW  = ROWS * RW;
  localparam int unsigned RCW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned LW  = $clog2(ADD_LATENCY + 1) + 1;

  typedef enum logic [2:0] {StIdle, StLoadA, StLoadB, StWait, StDrain} state_e;

  state_e          state_q;
  logic [RCW-1:0]  row_q;
  logic [LW-1:0]   lat_q;
  logic [MW-1:0]   result_q;
  logic            busy_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic            done_q;

  logic beat;
  logic last_row;
  assign beat     = strm.in_valid & in_ready_q;
  assign last_row = (row_q == RCW'(ROWS - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      row_q       <= '0;
      lat_q       <= '0;
      adder_a     <= '0;
      adder_b     <= '0;
      result_q    <= '0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q    <= StLoadA;
            row_q      <= '0;
            busy_q     <= 1'b1;
            in_ready_q <= 1'b1;
          end
        end
        StLoadA, StLoadB: begin
          if (beat) begin
            if (state_q == StLoadA) adder_a[row_q*RW +: RW] <= strm.in_row;
            else                    adder_b[row_q*RW +: RW] <= strm.in_row;
            if (last_row) begin
              row_q <= '0;
              if (state_q == StLoadA) begin
                state_q <= StLoadB;
              end else begin
                state_q    <= StWait;
                in_ready_q <= 1'b0;
                lat_q      <= '0;
              end
            end else begin
              row_q <= row_q + 1'b1;
            end
          end
        end
        StWait: begin
          // ADD_LATENCY+1 cycles: the last B row needs one edge to reach the adder input.
          if (lat_q == LW'(ADD_LATENCY)) begin
            result_q    <= adder_c;
            state_q     <= StDrain;
            row_q       <= '0;
            out_valid_q <= 1'b1;
          end else begin
            lat_q <= lat_q + 1'b1;
          end
        end
        StDrain: begin
          if (strm.out_ready) begin
            if (last_row) begin
              state_q     <= StIdle;
              row_q       <= '0;
              out_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              row_q <= row_q + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign strm.in_ready  = in_ready_q;
  assign strm.out_valid = out_valid_q;
  assign strm.out_row   = out_valid_q ? result_q[row_q*RW +: RW] : '0;
  assign strm.out_last  = out_valid_q & last_row;

`ifdef MTRX_ADD_CTRL_OVF_EN
  logic [ROWS*COLS-1:0] ovf_q;

  // Unsigned wrap in a lane shows up as the sum being smaller than operand A.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ovf_q <= '0;
    end else if (state_q == StWait && lat_q == LW'(ADD_LATENCY)) begin
      for (int i = 0; i < ROWS * COLS; i++) begin
        ovf_q[i] <= (adder_c[i*W +: W] < adder_a[i*W +: W]);
      end
    end
  end

  assign strm.out_ovf = out_valid_q ? ovf_q[row_q*COLS +: COLS] : '0;
`else
  assign strm.out_ovf = '0;
`endif

endmodule

// File: tb/tb_mtrx_add_ctrl.sv
// Self-checking bench for mtrx_add_ctrl with a behavioural registered adder.
// Expected results come from plain per-element arithmetic on the stored matrices.
module tb_mtrx_add_ctrl;
  localparam int unsigned ROWS = 5;
  localparam int unsigned COLS = 5;
  localparam int unsigned W    = 8;
  localparam int unsigned N    = ROWS * COLS;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic           busy;
  logic           done;
  logic [N*W-1:0] adder_a;
  logic [N*W-1:0] adder_b;
  logic [N*W-1:0] adder_c = '0;

  mtrx_add_ctrl_if #(.COLS(COLS), .W(W)) strm ();

  mtrx_add_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .W(W), .ADD_LATENCY(1)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .busy    (busy),
    .adder_a (adder_a),
    .adder_b (adder_b),
    .adder_c (adder_c),
    .done    (done),
    .strm    (strm)
  );

  always #5 clock = ~clock;

  // External registered adder: one clock of latency, lanes independent.
  always @(posedge clock) begin
    for (int i = 0; i < N; i++) adder_c[i*W +: W] <= adder_a[i*W +: W] + adder_b[i*W +: W];
  end

  logic [7:0] a_m [N];
  logic [7:0] b_m [N];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [COLS*W-1:0] row_of(input bit is_b, input int r);
    logic [COLS*W-1:0] v;
    for (int c = 0; c < COLS; c++) v[c*W +: W] = is_b ? b_m[r*COLS+c] : a_m[r*COLS+c];
    return v;
  endfunction

  function automatic logic [COLS*W-1:0] exp_row(input int r);
    logic [COLS*W-1:0] v;
    int s;
    for (int c = 0; c < COLS; c++) begin
      s = int'(a_m[r*COLS+c]) + int'(b_m[r*COLS+c]);
      v[c*W +: W] = 8'(s % 256);
    end
    return v;
  endfunction

  function automatic logic [COLS-1:0] exp_ovf(input int r);
    logic [COLS-1:0] v;
    v = '0;
`ifdef MTRX_ADD_CTRL_OVF_EN
    for (int c = 0; c < COLS; c++) v[c] = (int'(a_m[r*COLS+c]) + int'(b_m[r*COLS+c])) > 255;
`endif
    return v;
  endfunction

  // in_mode: 0 valid held high, 1 toggling, 2 random.
  // out_mode: 0 ready held high, 1 three-cycle stall on row 2, 2 random.
  task automatic do_op(input int in_mode, input int out_mode, input bit glitch);
    int beats, cyc, r, stall, waitc;
    logic v, rdy, acc;
    logic [N*W-1:0] ea, eb;
    for (int i = 0; i < N; i++) begin
      ea[i*W +: W] = a_m[i];
      eb[i*W +: W] = b_m[i];
    end
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("busy_on", busy, 1);
    check("in_ready_on", strm.in_ready, 1);
    beats = 0;
    cyc = 0;
    while (beats < 2 * ROWS && cyc < 300) begin
      case (in_mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      strm.in_valid = v;
      strm.in_row   = (beats < ROWS) ? row_of(1'b0, beats) : row_of(1'b1, beats - ROWS);
      start = glitch && (beats == 7);
      acc = v && strm.in_ready;
      @(negedge clock);
      cyc++;
      if (acc) beats++;
    end
    check("load_beats", beats, 2 * ROWS);
    if (in_mode == 0) check("load_cycles", cyc, 2 * ROWS);
    strm.in_valid = 1'b0;
    start = 1'b0;
    check("adder_a", adder_a, ea);
    check("adder_b", adder_b, eb);
    check("in_ready_wait", strm.in_ready, 0);
    check("busy_wait", busy, 1);
    check("out_valid_wait", strm.out_valid, 0);
    waitc = 0;
    while (!strm.out_valid && waitc < 20) begin
      @(negedge clock);
      waitc++;
    end
    check("wait_len", waitc, 2);
    r = 0;
    stall = 0;
    cyc = 0;
    while (r < ROWS && cyc < 300) begin
      check("out_valid", strm.out_valid, 1);
      check("out_row", strm.out_row, exp_row(r));
      check("out_last", strm.out_last, (r == ROWS - 1));
      check("out_ovf", strm.out_ovf, exp_ovf(r));
      check("in_ready_drain", strm.in_ready, 0);
      case (out_mode)
        0:       rdy = 1'b1;
        1:       rdy = !(r == 2 && stall < 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      if (r == 2 && !rdy) stall++;
      start = glitch && (r == 1);
      strm.out_ready = rdy;
      @(negedge clock);
      cyc++;
      if (rdy) r++;
    end
    check("drain_rows", r, ROWS);
    if (out_mode == 0) check("drain_cycles", cyc, ROWS);
    if (out_mode == 1) check("stall_cycles", stall, 3);
    start = 1'b0;
    strm.out_ready = 1'b0;
    check("done_pulse", done, 1);
    check("busy_off", busy, 0);
    check("out_valid_off", strm.out_valid, 0);
    @(negedge clock);
    check("done_single", done, 0);
    check("busy_idle", busy, 0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_in_ready"}, strm.in_ready, 0);
    check({tag, "_out_valid"}, strm.out_valid, 0);
    check({tag, "_out_last"}, strm.out_last, 0);
    check({tag, "_out_ovf"}, strm.out_ovf, 0);
    check({tag, "_out_row"}, strm.out_row, 0);
    check({tag, "_adder_a"}, adder_a, 0);
    check({tag, "_adder_b"}, adder_b, 0);
  endtask

  task automatic set_ramp();
    for (int i = 0; i < N; i++) begin
      a_m[i] = 8'(i + 1);
      b_m[i] = 8'(N - i);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    strm.in_valid  = 1'b0;
    strm.in_row    = '0;
    strm.out_ready = 1'b0;
    repeat (2) @(negedge clock);
    check_reset_state("reset");
    reset = 1'b0;
    @(negedge clock);
    check_reset_state("idle");

    set_ramp();
    do_op(0, 0, 1'b0);
    do_op(1, 0, 1'b0);
    do_op(0, 1, 1'b0);

    for (int i = 0; i < N; i++) begin
      a_m[i] = 8'hF0;
      b_m[i] = 8'h20;
    end
    do_op(0, 0, 1'b0);

    // Abort after 3 B beats.
    set_ramp();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int k = 0; k < ROWS + 3; k++) begin
      strm.in_valid = 1'b1;
      strm.in_row   = (k < ROWS) ? row_of(1'b0, k) : row_of(1'b1, k - ROWS);
      @(negedge clock);
    end
    strm.in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check_reset_state("abort");
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    do_op(0, 0, 1'b0);

    do_op(0, 0, 1'b1);

    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < N; i++) begin
        a_m[i] = 8'($urandom_range(0, 255));
        b_m[i] = 8'($urandom_range(0, 255));
      end
      do_op(2, 2, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
